// File: rtl/add_mul_stage_ctrl.sv
// Stage sequencer for one add_mul_block tile: accepts a stage command, holds the tile
// configuration, counts source beats, drains result beats and reports a status pulse.
module add_mul_stage_ctrl #(
  parameter int DATA_NUM  = 192,
  parameter int CNT_W     = 10,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [2:0] cmd_sel_a,
  input  logic [2:0] cmd_sel_b,
  input  logic [1:0] cmd_out_dir,
  input  logic       abort,
  input  logic       src_tvalid,
  input  logic       res_tvalid,
  output logic       stage_start,
  output logic [2:0] block_en,
  output logic [2:0] input_sel_a,
  output logic [2:0] input_sel_b,
  output logic [2:0] add_output_sel,
  output logic [2:0] mul_output_sel,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_status
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_MUL   = 2'd1;
  localparam logic [1:0] MODE_SELF1 = 2'd2;
  localparam logic [1:0] MODE_SELF2 = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_CFG     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic cfg_invalid(input logic [1:0] mode, input logic [2:0] sa,
                                       input logic [2:0] sb, input logic [1:0] od);
    logic routed;
    routed = (mode == MODE_ADD) || (mode == MODE_MUL);
    return (od == 2'b00) || (routed && (!is_onehot3(sa) || !is_onehot3(sb)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != CNT_W'(DATA_NUM)))
      return c + CNT_W'(1);
    return c;
  endfunction

  state_t             state, state_d;
  logic [1:0]         status_d;
  logic [SET_W-1:0]   setup_cnt, setup_cnt_d;
  logic [CNT_W-1:0]   in_cnt, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt, out_cnt_d, out_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_d, tmo_nxt;
  logic               take;

  logic [1:0]         mode_p0;
  logic [2:0]         sel_a_p0;
  logic [2:0]         sel_b_p0;
  logic [1:0]         out_dir_p0;
  logic               cfg_err_p0;

  logic [1:0]         mode_e;
  logic [2:0]         sel_a_e;
  logic [2:0]         sel_b_e;
  logic [1:0]         out_dir_e;
  logic               err_e;
  logic               cfg_hold;
  logic [2:0]         be_d, ia_d, ib_d, ao_d, mo_d;

  assign take = (state == S_IDLE) && cmd_valid && cmd_ready;

  // p0: command fields captured on the handshake; data only, no reset
  always_ff @(posedge clk) begin
    if (take) begin
      mode_p0    <= cmd_mode;
      sel_a_p0   <= cmd_sel_a;
      sel_b_p0   <= cmd_sel_b;
      out_dir_p0 <= cmd_out_dir;
      cfg_err_p0 <= cfg_invalid(cmd_mode, cmd_sel_a, cmd_sel_b, cmd_out_dir);
    end
  end

  always_comb begin
    state_d     = state;
    status_d    = ST_OK;
    setup_cnt_d = setup_cnt;
    in_cnt_d    = in_cnt;
    out_cnt_d   = out_cnt;
    tmo_cnt_d   = tmo_cnt;
    out_nxt     = sat_inc(out_cnt, res_tvalid);
    tmo_nxt     = tmo_cnt + TMO_W'(1);
    unique case (state)
      S_IDLE: begin
        if (take) begin
          state_d     = S_SETUP;
          setup_cnt_d = '0;
        end
      end
      S_SETUP: begin
        setup_cnt_d = setup_cnt + SET_W'(1);
        // A bad command spends one cycle here so its done lands like a normal decode would
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (cfg_err_p0) begin
          state_d  = S_DONE;
          status_d = ST_CFG;
        end else if (setup_cnt == SET_W'(SETUP_CYC - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        out_cnt_d = out_nxt;
        tmo_cnt_d = '0;
        if (src_tvalid)
          in_cnt_d = in_cnt + CNT_W'(1);
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (src_tvalid && (in_cnt == CNT_W'(DATA_NUM - 1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_cnt_d = out_nxt;
        tmo_cnt_d = res_tvalid ? '0 : tmo_nxt;
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (out_nxt == CNT_W'(DATA_NUM)) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (!res_tvalid && (tmo_nxt == TMO_W'(TIMEOUT - 1))) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if ((state_d == S_DONE) || (state_d == S_IDLE)) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      tmo_cnt_d = '0;
    end
  end

  // Config decode looks at the live command on the handshake cycle, the latched copy afterwards
  always_comb begin
    mode_e    = take ? cmd_mode    : mode_p0;
    sel_a_e   = take ? cmd_sel_a   : sel_a_p0;
    sel_b_e   = take ? cmd_sel_b   : sel_b_p0;
    out_dir_e = take ? cmd_out_dir : out_dir_p0;
    err_e     = take ? cfg_invalid(cmd_mode, cmd_sel_a, cmd_sel_b, cmd_out_dir) : cfg_err_p0;
    cfg_hold  = ((state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_DRAIN)) && !err_e;
    be_d = '0;
    ia_d = '0;
    ib_d = '0;
    ao_d = '0;
    mo_d = '0;
    if (cfg_hold) begin
      case (mode_e)
        MODE_ADD: begin
          be_d = 3'b001;
          ia_d = sel_a_e;
          ib_d = sel_b_e;
          ao_d = {1'b0, out_dir_e};
        end
        MODE_MUL: begin
          be_d = 3'b001;
          ia_d = sel_a_e;
          ib_d = sel_b_e;
          mo_d = {1'b0, out_dir_e};
        end
        MODE_SELF1: begin
          be_d = 3'b010;
          ao_d = {1'b0, out_dir_e};
        end
        MODE_SELF2: begin
          be_d = 3'b100;
          ao_d = {1'b0, out_dir_e};
        end
      endcase
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      setup_cnt      <= '0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      tmo_cnt        <= '0;
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      done_status    <= ST_OK;
      stage_start    <= 1'b0;
      block_en       <= '0;
      input_sel_a    <= '0;
      input_sel_b    <= '0;
      add_output_sel <= '0;
      mul_output_sel <= '0;
    end else begin
      state          <= state_d;
      setup_cnt      <= setup_cnt_d;
      in_cnt         <= in_cnt_d;
      out_cnt        <= out_cnt_d;
      tmo_cnt        <= tmo_cnt_d;
      cmd_ready      <= (state_d == S_IDLE);
      busy           <= (state_d != S_IDLE);
      done           <= (state_d == S_DONE);
      done_status    <= status_d;
      stage_start    <= (state_d == S_RUN) || (state_d == S_DRAIN);
      block_en       <= be_d;
      input_sel_a    <= ia_d;
      input_sel_b    <= ib_d;
      add_output_sel <= ao_d;
      mul_output_sel <= mo_d;
    end
  end

endmodule
